// File: rtl/anti_theft_pkg.sv
// Shared encodings for the anti-theft control slice: FSM states, timer
// interval codes and the start-request bundle passed to the timer handshake.
package anti_theft_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ARMED         = 3'd0;
  localparam logic [STATE_W-1:0] TRIGGERED     = 3'd1;
  localparam logic [STATE_W-1:0] SOUND_ALARM   = 3'd2;
  localparam logic [STATE_W-1:0] DIS_IGN_ON    = 3'd3;
  localparam logic [STATE_W-1:0] DIS_IGN_OFF   = 3'd4;
  localparam logic [STATE_W-1:0] DIS_DOOR_OPEN = 3'd5;
  localparam logic [STATE_W-1:0] ARM_WAIT      = 3'd6;

  localparam logic [1:0] ARM_DELAY       = 2'b00;
  localparam logic [1:0] DRIVER_DELAY    = 2'b01;
  localparam logic [1:0] PASSENGER_DELAY = 2'b10;
  localparam logic [1:0] ALARM_ON        = 2'b11;

  typedef struct packed {
    logic       vld;
    logic [1:0] ivl;
  } start_req_t;

endpackage

// File: rtl/anti_theft_fsm_timer_start_ctrl.sv
// Timer start handshake: shadows the timer's busy state, masks stale expiry
// right after a start, and defers a request made while the timer is running.
module timer_start_ctrl
  import anti_theft_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       req_vld,
  input  logic [1:0] req_ivl,
  input  logic       clear_pending,
  input  logic       expired,
  output logic       start_timer,
  output logic [1:0] interval,
  output logic       expired_evt
);

  logic busy, guard, pending;
  logic expired_raw, launch;

  assign expired_raw = busy & ~guard & expired;
  // A deferred start swallows the expiry that frees the timer.
  assign expired_evt = expired_raw & ~pending;
  assign launch      = (~busy | expired_raw) & (req_vld | (pending & ~clear_pending));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      start_timer <= 1'b0;
      interval    <= ARM_DELAY;
      busy        <= 1'b0;
      guard       <= 1'b0;
      pending     <= 1'b0;
    end else begin
      start_timer <= launch;
      guard       <= launch;
      if (req_vld)
        interval <= req_ivl;
      if (launch)
        busy <= 1'b1;
      else if (expired_raw)
        busy <= 1'b0;
      if (clear_pending || launch)
        pending <= 1'b0;
      else if (req_vld)
        pending <= 1'b1;
    end
  end

endmodule

// File: rtl/anti_theft_fsm.sv
// Anti-theft control FSM: arms/disarms, drives status LED and siren, and
// requests countdown intervals from the system timer.
// Optional fuel-pump immobiliser enabled by defining ANTI_THEFT_FUEL_PUMP_EN.
module anti_theft_fsm
  import anti_theft_pkg::*;
#(
  parameter int unsigned BLINK_DIV    = 1,
  parameter bit          SIREN_PULSED = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ignition,
  input  logic       driver_door,
  input  logic       passenger_door,
  input  logic       reprogram,
  input  logic       expired,
  input  logic       one_hz_enable,
  input  logic       two_hz_enable,
  output logic       start_timer,
  output logic [1:0] interval,
  output logic       status_led,
  output logic       siren,
`ifdef ANTI_THEFT_FUEL_PUMP_EN
  input  logic       hidden_switch,
  input  logic       brake_pedal,
  output logic       fuel_pump,
  output logic [2:0] fsm_state
`else
  output logic [2:0] fsm_state
`endif
);

  localparam logic [3:0] BLINK_LAST = 4'(BLINK_DIV - 1);

  logic [STATE_W-1:0] state, state_n;
  start_req_t         req;
  logic               clear_pending, expired_evt;
  logic               doors_open, doors_q, doors_closed_edge;
  logic [3:0]         blink_cnt;

  assign doors_open        = driver_door | passenger_door;
  assign doors_closed_edge = doors_q & ~doors_open;
  assign fsm_state         = state;

  always_comb begin
    state_n       = state;
    req           = '0;
    clear_pending = 1'b0;
    if (reprogram) begin
      state_n       = ARMED;
      clear_pending = 1'b1;
    end else begin
      case (state)
        ARMED: begin
          // Ignition alone never disarms; driver door wins over passenger.
          if (driver_door) begin
            state_n = TRIGGERED;
            req     = '{vld: 1'b1, ivl: DRIVER_DELAY};
          end else if (passenger_door) begin
            state_n = TRIGGERED;
            req     = '{vld: 1'b1, ivl: PASSENGER_DELAY};
          end
        end
        TRIGGERED: begin
          if (ignition)         state_n = DIS_IGN_ON;
          else if (expired_evt) state_n = SOUND_ALARM;
        end
        SOUND_ALARM: begin
          if (ignition)
            state_n = DIS_IGN_ON;
          else if (expired_evt && !doors_open)
            state_n = ARMED;
          else if (doors_closed_edge)
            req = '{vld: 1'b1, ivl: ALARM_ON};
        end
        DIS_IGN_ON: begin
          if (!ignition) state_n = DIS_IGN_OFF;
        end
        DIS_IGN_OFF: begin
          if (ignition)         state_n = DIS_IGN_ON;
          else if (driver_door) state_n = DIS_DOOR_OPEN;
        end
        DIS_DOOR_OPEN: begin
          if (ignition) begin
            state_n = DIS_IGN_ON;
          end else if (!driver_door) begin
            state_n = ARM_WAIT;
            req     = '{vld: 1'b1, ivl: ARM_DELAY};
          end
        end
        ARM_WAIT: begin
          if (ignition) begin
            state_n = DIS_IGN_ON;
          end else if (expired_evt) begin
            state_n = ARMED;
          end else if (doors_open) begin
            state_n       = DIS_DOOR_OPEN;
            clear_pending = 1'b1;
          end
        end
        default: state_n = ARMED;
      endcase
    end
  end

  timer_start_ctrl u_start_ctrl (
    .clock         (clock),
    .reset         (reset),
    .req_vld       (req.vld),
    .req_ivl       (req.ivl),
    .clear_pending (clear_pending),
    .expired       (expired),
    .start_timer   (start_timer),
    .interval      (interval),
    .expired_evt   (expired_evt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ARMED;
      doors_q <= 1'b0;
    end else begin
      state   <= state_n;
      doors_q <= doors_open;
    end
  end

  // Outputs are decoded from the next state so they change with the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      status_led <= 1'b0;
      blink_cnt  <= '0;
    end else begin
      case (state_n)
        ARMED: begin
          if (state != ARMED) begin
            status_led <= 1'b0;
            blink_cnt  <= '0;
          end else if (one_hz_enable) begin
            if (blink_cnt == BLINK_LAST) begin
              status_led <= ~status_led;
              blink_cnt  <= '0;
            end else begin
              blink_cnt <= blink_cnt + 4'd1;
            end
          end
        end
        TRIGGERED, SOUND_ALARM: begin
          status_led <= 1'b1;
          blink_cnt  <= '0;
        end
        default: begin
          status_led <= 1'b0;
          blink_cnt  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      siren <= 1'b0;
    else if (state_n != SOUND_ALARM)
      siren <= 1'b0;
    else if (state != SOUND_ALARM)
      siren <= 1'b1;
    else if (SIREN_PULSED && two_hz_enable)
      siren <= ~siren;
  end

`ifdef ANTI_THEFT_FUEL_PUMP_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      fuel_pump <= 1'b0;
    else if (reprogram || !ignition || state_n == SOUND_ALARM)
      fuel_pump <= 1'b0;
    else if (hidden_switch && brake_pedal)
      fuel_pump <= 1'b1;
  end
`else
`endif

endmodule

// File: doc/anti_theft_fsm.md
Name: anti_theft_fsm

Overview:
Top-level control FSM of the automotive anti-theft system. It sits directly upstream of the system countdown timer. It selects the countdown interval, pulses the timer start input, and consumes the timer's `expired`, `one_hz_enable` and `two_hz_enable` outputs. It drives the status LED and the siren enable. The interval code feeds the time-parameter block, which combinationally returns the 4-bit `value` loaded by the timer.

Parameters:
BLINK_DIV, 1, number of `one_hz_enable` pulses per status-LED toggle in ARMED (range 1..15)
SIREN_PULSED, 1, 1: `siren` gated by a 2 Hz-toggled square wave; 0: `siren` steady high while alarming

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
ignition  in  1  ignition switch, already synchronised and debounced
driver_door  in  1  1 = driver door open, already synchronised and debounced
passenger_door  in  1  1 = any passenger door open, already synchronised and debounced
reprogram  in  1  one-cycle pulse after a parameter update; forces ARMED
expired  in  1  from timer; sticky until the next accepted start
one_hz_enable  in  1  from timer; one-cycle pulse
two_hz_enable  in  1  from timer; one-cycle pulse
start_timer  out  1  one-cycle start pulse to the timer (registered)
interval  out  2  00 T_ARM_DELAY, 01 T_DRIVER_DELAY, 10 T_PASSENGER_DELAY, 11 T_ALARM_ON
status_led  out  1  status indicator
siren  out  1  siren drive
fsm_state  out  3  current state encoding, for debug display

Behaviour:
- Reset values:
  - state = ARMED; start_timer = 0; interval = 00; status_led = 0; siren = 0.
  - busy = 0; pending = 0; guard = 0; blink counter = 0.
- State encodings (fsm_state): ARMED=0, TRIGGERED=1, SOUND_ALARM=2, DIS_IGN_ON=3, DIS_IGN_OFF=4, DIS_DOOR_OPEN=5, ARM_WAIT=6.
- All outputs are registered; state changes take effect on the edge after the causing input is sampled.
- Timer handshake:
  - The timer accepts a start only when idle, so the FSM keeps a shadow `busy` flag.
  - A "start request" sets `interval` and:
    - if !busy: pulses `start_timer` for one cycle and sets busy = 1, guard = 1;
    - if busy: sets pending = 1 with the requested interval held.
  - `guard` clears on the edge after the pulse. Stale `expired` is ignored while guard = 1.
  - expired_evt = busy & !guard & expired. On expired_evt, busy clears.
  - If pending = 1 at expired_evt: the state machine does not act on that event. It issues the held start on the next cycle and clears pending.
  - `interval` stays stable from the start request until the next request.
- Transitions (priority: reprogram > ignition > expired_evt > doors):
  - reprogram in any state -> ARMED. pending is cleared; busy is unchanged.
  - ARMED:
    - driver_door -> TRIGGERED, request 01 (driver wins if both doors open);
    - passenger_door -> TRIGGERED, request 10;
    - ignition alone does not disarm.
  - TRIGGERED:
    - ignition -> DIS_IGN_ON;
    - expired_evt -> SOUND_ALARM.
  - SOUND_ALARM:
    - ignition -> DIS_IGN_ON;
    - on every transition to all-doors-closed, request 11;
    - expired_evt with both doors closed -> ARMED;
    - expired_evt with a door open is ignored, and a new request 11 follows on close.
  - DIS_IGN_ON: !ignition -> DIS_IGN_OFF.
  - DIS_IGN_OFF:
    - ignition -> DIS_IGN_ON;
    - driver_door -> DIS_DOOR_OPEN.
  - DIS_DOOR_OPEN:
    - ignition -> DIS_IGN_ON;
    - !driver_door -> ARM_WAIT, request 00.
  - ARM_WAIT:
    - ignition -> DIS_IGN_ON;
    - any door open -> DIS_DOOR_OPEN, discard pending;
    - expired_evt -> ARMED.
  - expired_evt in any other state only clears busy.
- status_led:
  - ARMED: toggles every BLINK_DIV `one_hz_enable` pulses; the counter clears on entry to ARMED.
  - TRIGGERED and SOUND_ALARM: 1.
  - All disarmed states: 0.
- siren: 1 only in SOUND_ALARM. With SIREN_PULSED = 1, a square wave toggled on each `two_hz_enable`, starting at 1 on entry.
- Asynchronous reset mid-operation: all outputs return to reset values immediately. The timer is reset by the same net.

Optional Feature:
ANTI_THEFT_FUEL_PUMP_EN
- Defined: adds inputs `hidden_switch` and `brake_pedal` and output `fuel_pump`.
  - `fuel_pump` sets when ignition & hidden_switch & brake_pedal are sampled high together.
  - It clears when ignition drops, on reprogram, or on reset.
  - It is forced to 0 in SOUND_ALARM.
- Undefined: these ports and this logic do not exist.

Decomposition:
- Package `anti_theft_pkg` holds:
  - state encodings;
  - interval codes (ARM_DELAY, DRIVER_DELAY, PASSENGER_DELAY, ALARM_ON);
  - the 3-bit state width.
- One sub-module, `timer_start_ctrl`, owns busy/pending/guard, the held interval and the start pulse.
- The FSM core issues requests and receives expired_evt.

Test Plan:
1. Release reset, BLINK_DIV = 1, ten `one_hz_enable` pulses -> fsm_state = 0, status_led toggles 10 times, siren = 0, start_timer never high.
2. ARMED, driver_door = 1 -> single start_timer pulse with interval = 01, status_led = 1; ignition = 1 before expired -> fsm_state = 3, status_led = 0, siren = 0.
3. ARMED, passenger_door = 1, timer runs out -> SOUND_ALARM, siren follows 2 Hz toggling; close door -> start with interval = 11; expired -> ARMED, siren = 0.
4. Disarm, ignition off, driver door open/close -> start with interval 00; reopen and close before expiry -> no start while busy; the old expired is not acted on; the next cycle issues start 00; second expiry -> ARMED.
5. Stale expired = 1 held from a previous run, new start issued -> no transition at the edge of the pulse; transition only after the new expiry.
6. reset driven 0 asynchronously mid-SOUND_ALARM -> siren = 0 and fsm_state = 0 before the next clock edge; reprogram pulse in TRIGGERED -> ARMED on the next edge.
